// File: rtl/dpwm_pkg.sv
// -----------------------------------------------------------------------------
// dpwm_pkg
// Shared constants for the multi-channel DPWM.
//   MODE_EDGE / MODE_CENTER : encodings of the Mode input and the mode shadow.
//   DIR_UP / DIR_DOWN       : counter direction encodings.
//   dir_e                   : state type of the up/down counter FSM.
// -----------------------------------------------------------------------------
package dpwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic {
      ST_UP   = DIR_UP,
      ST_DOWN = DIR_DOWN
   } dir_e;

endpackage

// File: rtl/dpwm_channel.sv
// -----------------------------------------------------------------------------
// dpwm_channel
// One PWM output: a duty shadow register plus the registered compare.
// Ports:
//   f_in     in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   load     in   copy duty_in into the duty shadow on this edge
//   en       in   run enable; output is forced low while clear
//   cnt      in   shared period counter, RES bits
//   duty_in  in   live duty word, RES bits
//   Signal_o out  registered PWM output
// -----------------------------------------------------------------------------
module dpwm_channel #(
   parameter int RES = 4
) (
   input  logic           f_in,
   input  logic           rst,
   input  logic           load,
   input  logic           en,
   input  logic [RES-1:0] cnt,
   input  logic [RES-1:0] duty_in,
   output logic           Signal_o
);

   logic [RES-1:0] r_duty_sh;
   logic           r_signal;

   // The compare uses the shadow as it was before this edge, so a duty word
   // loaded on the boundary edge first affects the cnt = 0 compare that
   // follows it, i.e. the whole new period and nothing of the old one.
   always_ff @(posedge f_in) begin
      if (rst) begin
         r_duty_sh <= '0;
         r_signal  <= 1'b0;
      end else begin
         if (load) begin
            r_duty_sh <= duty_in;
         end
         r_signal <= en & (cnt < r_duty_sh);
      end
   end

   assign Signal_o = r_signal;

endmodule

// File: rtl/dpwm_multi.sv
// -----------------------------------------------------------------------------
// dpwm_multi
// Multi-channel digital PWM generator with a runtime period, per-channel duty,
// edge- or center-aligned counting and glitch-free (shadowed) updates that
// take effect only at period boundaries.
// Ports:
//   f_in      in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   En        in   run enable
//   Mode      in   0 = edge-aligned, 1 = center-aligned
//   Period    in   period length in counts, RES bits (0 behaves as 1)
//   Ref       in   packed duty words, channel i at Ref[i*RES +: RES]
//   Signal_o  out  registered PWM outputs, one per channel
//   Sync_o    out  registered one-cycle pulse on the first cycle of a period
// -----------------------------------------------------------------------------
module dpwm_multi
   import dpwm_pkg::*;
#(
   parameter int CH  = 2,
   parameter int RES = 4
) (
   input  logic              f_in,
   input  logic              rst,
   input  logic              En,
   input  logic              Mode,
   input  logic [RES-1:0]    Period,
   input  logic [CH*RES-1:0] Ref,
   output logic [CH-1:0]     Signal_o,
   output logic              Sync_o
);

   // Counter / direction state and period/mode shadows.
   logic [RES-1:0] r_cnt;
   logic [RES-1:0] w_cnt_next;
   dir_e           r_dir;
   dir_e           w_dir_next;
   logic [RES-1:0] r_period_sh;
   logic           r_mode_sh;
   logic           r_sync;

   // Boundary strobe: high on the edge that moves the counter to (UP, 0),
   // and on every edge while disabled so the shadows track the inputs.
   logic           w_load;

   // Last count value of the up ramp, P-1 with P = max(Period_sh, 1).
   // A shadowed period of 0 therefore shares the P = 1 behaviour.
   logic [RES-1:0] w_p_last;

   assign w_p_last = (r_period_sh == '0) ? '0 : (r_period_sh - 1'b1);

   // -------------------------------------------------------------------------
   // Counter FSM, state register
   // -------------------------------------------------------------------------
   always_ff @(posedge f_in) begin
      if (rst) begin
         r_cnt <= '0;
         r_dir <= ST_UP;
      end else begin
         r_cnt <= w_cnt_next;
         r_dir <= w_dir_next;
      end
   end

   // -------------------------------------------------------------------------
   // Counter FSM, next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_cnt_next = r_cnt;
      w_dir_next = r_dir;
      w_load     = 1'b0;

      if (!En) begin
         // Idle: park at the start of a period, ready for the next run.
         w_cnt_next = '0;
         w_dir_next = ST_UP;
         w_load     = 1'b1;
      end else if (r_mode_sh == MODE_EDGE) begin
         // Saw-tooth. Direction is forced UP so that a switch from center
         // mode can never leave a stale DOWN behind. The >= keeps the wrap
         // safe even if cnt were ever above the current last value.
         w_dir_next = ST_UP;
         if (r_cnt >= w_p_last) begin
            w_cnt_next = '0;
            w_load     = 1'b1;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end else begin
         // Triangle. Both the peak (P-1) and the valley (0) are visited
         // twice, giving 2P cycles per period with a symmetric compare.
         case (r_dir)
            ST_UP: begin
               if (r_cnt >= w_p_last) begin
                  // Turn around and repeat the peak value once.
                  w_dir_next = ST_DOWN;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            ST_DOWN: begin
               if (r_cnt == '0) begin
                  // Valley repeat doubles as the period boundary.
                  w_dir_next = ST_UP;
                  w_load     = 1'b1;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            default: begin
               w_cnt_next = '0;
               w_dir_next = ST_UP;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Period / mode shadows and the sync pulse
   // -------------------------------------------------------------------------
   always_ff @(posedge f_in) begin
      if (rst) begin
         r_period_sh <= '0;
         r_mode_sh   <= MODE_EDGE;
         r_sync      <= 1'b0;
      end else begin
         if (w_load) begin
            r_period_sh <= Period;
            r_mode_sh   <= Mode;
         end
         // Registered alongside the channel compares so the pulse lines up
         // with the first compare cycle of each period.
         r_sync <= En & (r_dir == ST_UP) & (r_cnt == '0);
      end
   end

   assign Sync_o = r_sync;

   // -------------------------------------------------------------------------
   // Per-channel duty shadow and compare
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         dpwm_channel #(
            .RES (RES)
         ) u_ch (
            .f_in     (f_in),
            .rst      (rst),
            .load     (w_load),
            .en       (En),
            .cnt      (r_cnt),
            .duty_in  (Ref[gi*RES +: RES]),
            .Signal_o (Signal_o[gi])
         );
      end
   endgenerate

endmodule
